// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the multicycle datapath (master) and the
// unified instruction/data memory (slave).
//   MemReq    : request strobe, held high until MemReady is seen
//   MemW      : 1 = write, 0 = read
//   Adr       : byte address
//   WriteData : store data
//   ReadData  : registered read data
//   MemReady  : response valid / access complete
//   MemErr    : qualifies MemReady, 1 = misaligned or out-of-range access
// ---------------------------------------------------------------------------
interface mem_responder_if;
    logic        MemReq;
    logic        MemW;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;

    modport master (
        output MemReq, MemW, Adr, WriteData,
        input  ReadData, MemReady, MemErr
    );

    modport slave (
        input  MemReq, MemW, Adr, WriteData,
        output ReadData, MemReady, MemErr
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Unified word-addressed memory slave for the multicycle ARM datapath.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, and is
// committed on the edge that enters DONE. DONE is held until MemReq drops
// (four-phase handshake). Misaligned or out-of-range accesses complete with
// the same timing but report MemErr and never touch the array.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : mem_responder_if.slave (MemReq, MemW, Adr, WriteData in;
//           ReadData, MemReady, MemErr out)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);

    localparam int         WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [3:0]  cnt;
    logic        accept;
    logic        commit;

    // Request fields captured at acceptance
    logic        lat_w;
    logic [31:0] lat_adr;
    logic [31:0] lat_wdata;

    // Fields used on the commit edge. With LATENCY=0 the commit happens on
    // the acceptance edge itself, so the bus values are used directly.
    logic                  c_w;
    logic [31:0]           c_adr;
    logic [31:0]           c_wdata;
    logic [DEPTH_LOG2-1:0] c_idx;
    logic                  c_err;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [WORDS];

    // Misaligned, or any address bit above the stored word range set
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
    endfunction

    assign c_w     = (state == S_IDLE) ? bus.MemW      : lat_w;
    assign c_adr   = (state == S_IDLE) ? bus.Adr       : lat_adr;
    assign c_wdata = (state == S_IDLE) ? bus.WriteData : lat_wdata;
    assign c_idx   = c_adr[DEPTH_LOG2+1:2];
    assign c_err   = addr_err(c_adr);

    // Next-state / control decode
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.MemReq) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        next_state = S_DONE;
                        commit     = 1'b1;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // The <= guards against a stuck counter; cnt never reaches 0 here
                if (cnt <= 4'd1) begin
                    next_state = S_DONE;
                    commit     = 1'b1;
                end
            end
            S_DONE: begin
                if (!bus.MemReq) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Control state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt <= LAT4;
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                err_q <= c_err;
            end else if (state == S_DONE && next_state == S_IDLE) begin
                err_q <= 1'b0;
            end
        end
    end

    // Read data register: loaded on read commits and on any error commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= 32'd0;
        end else if (commit && (c_err || !c_w)) begin
            rdata_q <= c_err ? 32'd0 : mem[c_idx];
        end
    end

    // Request capture; later bus changes are ignored until the next accept
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_w     <= bus.MemW;
            lat_adr   <= bus.Adr;
            lat_wdata <= bus.WriteData;
        end
    end

    // Array write; the reset gate keeps a LATENCY=0 request from committing
    // while reset is held
    always_ff @(posedge clk) begin
        if (commit && c_w && !c_err && !reset) begin
            mem[c_idx] <= c_wdata;
        end
    end

    assign bus.MemReady = (state == S_DONE);
    assign bus.MemErr   = err_q;
    assign bus.ReadData = rdata_q;

endmodule
